// File: rtl/uart_tx_param.sv
// Parametrised UART frame transmitter: start bit, DATA_W data bits LSB-first,
// optional parity bit, then one or two stop bits, each held CLKS_PER_BIT clocks.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic [2:0]        state_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  // The bit counter is shared: it counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    bit_end = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          shift_d = data;
          par_d   = (PARITY == 2) ? ~(^data) : ^data;
          state_d = S_START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    busy_d = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready     = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three configurations run in parallel, each
// with a frame-level reference model feeding a queue that a line monitor drains.
module tb_uart_tx_param;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } item_t;

  localparam logic [5:0] IDLE_P = 6'b010001;

  logic clk = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Configuration table, k: 0=DATA_W 1=CLKS_PER_BIT 2=PARITY 3=STOP_BITS.
  function automatic int cfg(int g, int k);
    case (g * 4 + k)
      0: return 8;   1: return 4;   2: return 0;   3: return 1;
      4: return 8;   5: return 3;   6: return 1;   7: return 1;
      8: return 5;   9: return 1;  10: return 2;  11: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg_g
    localparam int DW   = cfg(g, 0);
    localparam int CPB  = cfg(g, 1);
    localparam int PAR  = cfg(g, 2);
    localparam int STOP = cfg(g, 3);
    localparam int NB   = 1 + DW + ((PAR != 0) ? 1 : 0) + STOP;
    localparam int F    = NB * CPB;

    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          ready, tx, busy;
    logic [2:0]    state_out;

    item_t      sb[$];
    bit         rdy_m = 1'b1;
    int         left_m = 0;
    int         cyc_m = 0;
    bit         in_frame = 1'b0;
    int         c = 0;
    bit         done_g = 1'b0;
    logic       exp_tx[32];
    logic [2:0] exp_st[32];
    logic [5:0] act;

    uart_tx_param #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(STOP)
    ) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .data(data),
      .ready(ready), .tx(tx), .busy(busy), .state_out(state_out)
    );

    task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d, input int n);
      repeat (n) begin
        @(negedge clk);
        rst_n = r;
        valid = v;
        data  = d[DW-1:0];
      end
    endtask

    // Frame-level model: an accepted word keeps the transmitter busy for F edges.
    initial forever begin
      @(posedge clk);
      cyc_m++;
      if (!rst_n) begin
        rdy_m  = 1'b1;
        left_m = 0;
      end else if (rdy_m && valid) begin
        sb.push_back('{cyc_m, 16'(data)});
        rdy_m  = 1'b0;
        left_m = F;
      end else if (!rdy_m) begin
        left_m--;
        if (left_m == 0) rdy_m = 1'b1;
      end
    end

    initial forever begin
      @(posedge clk);
      #1;
      act = {busy, ready, state_out, tx};
      if (!rst_n) begin
        checkOutput($sformatf("cfg%0d reset outputs", g), 32'(act), 32'(IDLE_P));
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          checkOutput($sformatf("cfg%0d frame start has queued word", g), 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            item_t it;
            int n;
            it = sb.pop_front();
            checkOutput($sformatf("cfg%0d start cycle", g), cyc_m, it.cyc);
            exp_tx[0] = 1'b0;
            exp_st[0] = 3'd1;
            for (int i = 0; i < DW; i++) begin
              exp_tx[1 + i] = it.d[i];
              exp_st[1 + i] = 3'd2;
            end
            n = 1 + DW;
            if (PAR != 0) begin
              exp_tx[n] = (PAR == 1) ? ^it.d : ~(^it.d);
              exp_st[n] = 3'd3;
              n++;
            end
            for (int i = 0; i < STOP; i++) begin
              exp_tx[n + i] = 1'b1;
              exp_st[n + i] = 3'd4;
            end
            in_frame = 1'b1;
            c = 0;
          end
        end
        if (sb.size() != 0) begin
          checkOutput($sformatf("cfg%0d accept without frame start", g), sb.size(), 0);
          sb.delete();
        end
        if (in_frame) begin
          if (c < F) begin
            checkOutput($sformatf("cfg%0d bit %0d cycle %0d {busy,ready,state,tx}", g, c / CPB, c),
                        32'(act), 32'({1'b1, 1'b0, exp_st[c / CPB], exp_tx[c / CPB]}));
          end else begin
            checkOutput($sformatf("cfg%0d ready after frame", g), 32'(act), 32'(IDLE_P));
            in_frame = 1'b0;
          end
          c++;
        end else begin
          checkOutput($sformatf("cfg%0d idle line", g), 32'(act), 32'(IDLE_P));
        end
      end
    end

    initial begin
      logic [15:0] words[6];
      words = '{16'h00A5, 16'h0007, 16'h0003, 16'h001F, 16'h0000, 16'hFFFF};
      rst_n = 1'b0;
      valid = 1'b1;
      data  = DW'(16'h00A5);
      repeat (3) @(posedge clk);
      applyStimulus(1'b1, 1'b0, 16'h0, 2);

      foreach (words[i]) begin
        applyStimulus(1'b1, 1'b1, words[i], 1);
        applyStimulus(1'b1, 1'b0, 16'h0, F + 2);
      end

      // A request while busy must be dropped, not queued.
      applyStimulus(1'b1, 1'b1, 16'h0055, 1);
      applyStimulus(1'b1, 1'b0, 16'h0, 2 * CPB);
      applyStimulus(1'b1, 1'b1, 16'h003C, 1);
      applyStimulus(1'b1, 1'b0, 16'h0, F + 2);

      applyStimulus(1'b1, 1'b1, 16'h0055, 1);
      applyStimulus(1'b1, 1'b1, 16'h00AA, F + 1);
      applyStimulus(1'b1, 1'b0, 16'h0, F + 3);

      applyStimulus(1'b1, 1'b1, 16'h0000, 1);
      applyStimulus(1'b1, 1'b0, 16'h0, 2 * CPB);
      applyStimulus(1'b0, 1'b0, 16'h0, 1);
      applyStimulus(1'b1, 1'b1, 16'h0096, 1);
      applyStimulus(1'b1, 1'b0, 16'h0, F + 2);

      for (int k = 0; k < 150; k++) begin
        applyStimulus(($urandom_range(0, 39) != 0), 1'($urandom), 16'($urandom),
                      $urandom_range(1, 3 * CPB));
      end

      applyStimulus(1'b1, 1'b0, 16'h0, F + 5);
      checkOutput($sformatf("cfg%0d drained {in_frame,queued,model_busy}", g),
                  32'({in_frame, sb.size() != 0, !rdy_m}), 0);
      done_g = 1'b1;
    end
  end

  initial begin
    int k;
    k = 0;
    while (!(cfg_g[0].done_g && cfg_g[1].done_g && cfg_g[2].done_g) && k < 60000) begin
      @(posedge clk);
      k++;
    end
    checkOutput("all configurations finished",
                32'({cfg_g[2].done_g, cfg_g[1].done_g, cfg_g[0].done_g}), 32'h7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
